// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for a weight-stationary systolic array (weight load, skewed streaming, deskewed result FIFO)
module pe_array_ctrl #(
    parameter int ARRAY_SIZE             = 2,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int RESULT_LAT             = 2,
    parameter int RES_DEPTH              = 8,
    parameter int CNT_W                  = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [CNT_W-1:0]                             num_vectors,
    output logic                                         busy,
    output logic                                         done,
    input  logic                                         w_valid,
    output logic                                         w_ready,
    input  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0]     w_data,
    input  logic                                         act_valid,
    output logic                                         act_ready,
    input  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0]     act_data,
    output logic                                         res_valid,
    input  logic                                         res_ready,
    output logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] res_data,
    output logic                                         arr_compute,
    output logic                                         arr_load_en,
    output logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0]     arr_data_ins,
    input  logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] arr_results
);
    localparam int N       = ARRAY_SIZE;
    localparam int CW      = COMPUTE_DATA_WIDTH;
    localparam int AW      = ACCUMULATOR_DATA_WIDTH;
    localparam int TAG_LEN = RESULT_LAT + N;
    localparam int PW      = $clog2(RES_DEPTH);
    localparam int FW      = PW + 1;
    localparam int RW      = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]   count, issued;
    logic [RW-1:0]      rows;
    logic [FW-1:0]      inflight, fcount;
    logic [TAG_LEN-1:0] tag;
    logic [PW-1:0]      wptr, rptr;
    logic [N*AW-1:0]    mem [RES_DEPTH];
    logic [N*CW-1:0]    skew_out;
    logic [N*AW-1:0]    aligned;
    logic               w_fire, accept, push, pop;

    assign w_ready      = state == LOAD_W;
    assign w_fire       = w_ready && w_valid;
    assign arr_load_en  = w_fire;
    assign arr_compute  = state == STREAM || state == DRAIN;
    // credit: every accepted vector already owns a FIFO slot
    assign act_ready    = state == STREAM && issued < count
                          && ({1'b0, inflight} + {1'b0, fcount}) < (FW+1)'(RES_DEPTH);
    assign accept       = act_ready && act_valid;
    assign arr_data_ins = w_fire ? w_data : arr_compute ? skew_out : '0;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign push         = tag[TAG_LEN-1];
    assign res_valid    = fcount != '0;
    assign pop          = res_ready && res_valid;
    assign res_data     = res_valid ? mem[rptr] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_W;
            LOAD_W:  if (w_fire && rows == RW'(N - 1)) state_nx = count == '0 ? DRAIN : STREAM;
            STREAM:  if (accept && issued + 1'b1 == count) state_nx = DRAIN;
            DRAIN:   if (inflight == '0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            issued   <= '0;
            rows     <= '0;
            inflight <= '0;
            tag      <= '0;
            fcount   <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            state    <= state_nx;
            if (state == IDLE && start) count <= num_vectors;
            rows     <= state == LOAD_W ? rows + RW'(w_fire) : '0;
            issued   <= state == IDLE ? '0 : issued + CNT_W'(accept);
            inflight <= inflight + FW'(accept) - FW'(push);
            tag      <= {tag[TAG_LEN-2:0], accept};
            fcount   <= fcount + FW'(push) - FW'(pop);
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= aligned;
    end

    // row i sees its element i+1 cycles after acceptance
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [i:0][CW-1:0] sr;
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else begin
                sr[0] <= accept ? act_data[i*CW +: CW] : '0;
                for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
            end
        end
        assign skew_out[i*CW +: CW] = sr[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*AW +: AW] = arr_results[j*AW +: AW];
        end else begin : g_reg
            logic [D-1:0][AW-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else begin
                    sr[0] <= arr_results[j*AW +: AW];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign aligned[j*AW +: AW] = sr[D-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fcount == FW'(RES_DEPTH) && !pop));
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: randomized self-checking bench with a behavioural systolic array and a matrix-product scoreboard
module tb_pe_array_ctrl;
    localparam int N = 2, CW = 4, AW = 16, RL = 2, DEPTH = 8, CNT_W = 8;

    logic clk = 0, rst = 1, start = 0, w_valid = 0, act_valid = 0, res_ready = 0;
    logic [CNT_W-1:0] num_vectors = '0;
    logic [N*CW-1:0]  w_data = '0, act_data = '0;
    logic [N*AW-1:0]  arr_results = '0;
    logic busy, done, w_ready, act_ready, res_valid, arr_compute, arr_load_en;
    logic [N*AW-1:0]  res_data;
    logic [N*CW-1:0]  arr_data_ins;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pe_array_ctrl #(.ARRAY_SIZE(N), .COMPUTE_DATA_WIDTH(CW), .ACCUMULATOR_DATA_WIDTH(AW),
                    .RESULT_LAT(RL), .RES_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .arr_compute(arr_compute), .arr_load_en(arr_load_en), .arr_data_ins(arr_data_ins),
        .arr_results(arr_results)
    );

    logic [CW-1:0]   tw [N][N];
    logic [CW-1:0]   wm [N][N];
    logic [N*CW-1:0] hist [16];
    logic [N*CW-1:0] vecs [$];
    logic [N*AW-1:0] exp_q [$], got_q [$];
    int cyc = 0, wrow = 0, load_cnt = 0, done_cnt = 0, overlap_cnt = 0, acc_cnt = 0;
    int comp_cnt = 0, done_comp = 0, first_acc = -1, first_res = -1;

    function automatic logic [N*AW-1:0] ref_result(input logic [N*CW-1:0] a);
        int s;
        ref_result = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += int'(a[i*CW +: CW]) * int'(tw[i][j]);
            ref_result[j*AW +: AW] = AW'(s);
        end
    endfunction

    // array model: column j at cycle c sums row i inputs seen at cycle c-RL-j+i
    always @(posedge clk) begin
        logic [N*AW-1:0] r;
        int s;
        if (!rst) begin
            if (arr_load_en) begin
                for (int j = 0; j < N; j++) wm[wrow][j] = arr_data_ins[j*CW +: CW];
                wrow = (wrow + 1) % N;
                load_cnt++;
            end
            if (arr_load_en && arr_compute) overlap_cnt++;
            if (arr_compute) comp_cnt++;
            if (done && arr_compute) done_comp++;
            if (act_valid && act_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_cnt++;
                exp_q.push_back(ref_result(act_data));
            end
            if (res_valid && first_res < 0) first_res = cyc;
            if (res_valid && res_ready) got_q.push_back(res_data);
            if (done) done_cnt++;
        end else wrow = 0;
        hist[cyc % 16] = arr_compute ? arr_data_ins : '0;
        cyc++;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += int'(hist[((cyc - RL - j + i) % 16 + 16) % 16][i*CW +: CW]) * int'(wm[i][j]);
            r[j*AW +: AW] = AW'(s);
        end
        arr_results <= r;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input bit fixed);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tw[r][c] = fixed ? CW'(r * N + c + 1) : CW'($urandom);
    endtask

    task automatic rand_vecs(input int n);
        vecs.delete();
        for (int k = 0; k < n; k++) vecs.push_back((N*CW)'($urandom));
    endtask

    task automatic start_job(input int n);
        load_cnt = 0; done_cnt = 0; overlap_cnt = 0; acc_cnt = 0; comp_cnt = 0; done_comp = 0;
        first_acc = -1; first_res = -1;
        exp_q.delete(); got_q.delete();
        num_vectors = CNT_W'(n);
        start = 1;
        cycles(1);
        start = 0;
    endtask

    task automatic send_weights(input int gap);
        for (int r = 0; r < N; r++) begin
            if (r > 0) cycles(gap);
            for (int c = 0; c < N; c++) w_data[c*CW +: CW] = tw[r][c];
            w_valid = 1;
            for (int t = 0; t < 200 && !w_ready; t++) cycles(1);
            checks++;
            if (!w_ready) begin $display("FAIL w_ready_timeout got=0 exp=1"); failures++; end
            cycles(1);
            w_valid = 0;
            w_data = (N*CW)'($urandom);
        end
    endtask

    task automatic send_acts(input bit toggle);
        foreach (vecs[k]) begin
            act_data = vecs[k];
            act_valid = 1;
            for (int t = 0; t < 400 && !act_ready; t++) cycles(1);
            checks++;
            if (!act_ready) begin $display("FAIL act_ready_timeout got=0 exp=1"); failures++; end
            cycles(1);
            act_valid = 0;
            act_data = (N*CW)'($urandom);
            if (toggle) cycles(1);
        end
    endtask

    task automatic wait_done(input int limit);
        for (int t = 0; t < limit && done_cnt == 0; t++) cycles(1);
        checks++;
        if (done_cnt == 0) begin $display("FAIL done_timeout got=0 exp=1"); failures++; end
        cycles(3);
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, w_ready, act_ready, res_valid, arr_compute, arr_load_en, arr_data_ins, res_data} !== '0) begin
            $display("FAIL reset_outputs got=%b busy=%b res_data=%h exp=0",
                     {busy, done, w_ready, act_ready, res_valid, arr_compute, arr_load_en}, busy, res_data);
            failures++;
        end
    endtask

    task automatic test_basic;
        set_weights(1);
        vecs.delete();
        vecs.push_back(8'h11);
        vecs.push_back(8'h02);
        res_ready = 1;
        start_job(2);
        checks++;
        if (busy !== 1'b1) begin $display("FAIL basic_busy got=%b exp=1", busy); failures++; end
        send_weights(0);
        send_acts(0);
        wait_done(200);
        checks++;
        if (load_cnt != 2) begin $display("FAIL basic_load_en got=%0d exp=2", load_cnt); failures++; end
        checks++;
        if (done_cnt != 1) begin $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); failures++; end
        checks++;
        if (got_q.size() != 2) begin $display("FAIL basic_result_count got=%0d exp=2", got_q.size()); failures++; end
        checks++;
        if (got_q.size() > 0 && got_q[0] !== {16'd6, 16'd4}) begin
            $display("FAIL basic_result0 got=%h exp=%h", got_q[0], {16'd6, 16'd4}); failures++;
        end
        checks++;
        if (got_q.size() > 1 && got_q[1] !== {16'd4, 16'd2}) begin
            $display("FAIL basic_result1 got=%h exp=%h", got_q[1], {16'd4, 16'd2}); failures++;
        end
        // pushed at accept+RL+N, visible at the FIFO head one cycle later
        checks++;
        if (first_res - first_acc != RL + N + 1) begin
            $display("FAIL basic_latency got=%0d exp=%0d", first_res - first_acc, RL + N + 1); failures++;
        end
        checks++;
        if (busy !== 1'b0 || overlap_cnt != 0) begin
            $display("FAIL basic_idle got busy=%b overlap=%0d exp busy=0 overlap=0", busy, overlap_cnt); failures++;
        end
    endtask

    task automatic test_bubbles;
        set_weights(0);
        rand_vecs(4);
        res_ready = 1;
        start_job(4);
        send_weights(0);
        send_acts(1);
        wait_done(300);
        checks++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            $display("FAIL bubbles_count got=%0d exp=4 accepted=%0d", got_q.size(), exp_q.size()); failures++;
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                $display("FAIL bubbles_result%0d got=%h exp=%h", k, got_q[k], exp_q[k]); failures++;
            end
        end
        checks++;
        if (done_cnt != 1) begin $display("FAIL bubbles_done got=%0d exp=1", done_cnt); failures++; end
    endtask

    task automatic test_backpressure;
        set_weights(0);
        rand_vecs(12);
        res_ready = 0;
        start_job(12);
        send_weights(0);
        fork
            send_acts(0);
            begin
                for (int t = 0; t < 200 && acc_cnt < DEPTH; t++) cycles(1);
                cycles(20);
                checks++;
                if (acc_cnt != DEPTH || act_ready !== 1'b0) begin
                    $display("FAIL bp_credit_stall got accepted=%0d act_ready=%b exp accepted=%0d act_ready=0",
                             acc_cnt, act_ready, DEPTH);
                    failures++;
                end
                checks++;
                if (res_valid !== 1'b1 || done_cnt != 0) begin
                    $display("FAIL bp_held got res_valid=%b done=%0d exp res_valid=1 done=0", res_valid, done_cnt);
                    failures++;
                end
                res_ready = 1;
            end
        join
        wait_done(400);
        checks++;
        if (got_q.size() != 12 || exp_q.size() != 12) begin
            $display("FAIL bp_count got=%0d exp=12 accepted=%0d", got_q.size(), exp_q.size()); failures++;
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                $display("FAIL bp_result%0d got=%h exp=%h", k, got_q[k], exp_q[k]); failures++;
            end
        end
    endtask

    task automatic test_zero;
        set_weights(0);
        res_ready = 1;
        start_job(0);
        send_weights(0);
        wait_done(100);
        checks++;
        if (load_cnt != 2 || done_cnt != 1 || got_q.size() != 0) begin
            $display("FAIL zero_job got loads=%0d done=%0d results=%0d exp loads=2 done=1 results=0",
                     load_cnt, done_cnt, got_q.size());
            failures++;
        end
        checks++;
        if (comp_cnt != 1 || done_comp != 0) begin
            $display("FAIL zero_compute got cycles=%0d in_done=%0d exp cycles=1 in_done=0", comp_cnt, done_comp);
            failures++;
        end
    endtask

    task automatic test_gaps;
        set_weights(0);
        rand_vecs(3);
        res_ready = 1;
        start_job(3);
        send_weights(2);
        send_acts(0);
        wait_done(200);
        checks++;
        if (load_cnt != 2 || overlap_cnt != 0) begin
            $display("FAIL gaps_load_en got loads=%0d overlap=%0d exp loads=2 overlap=0", load_cnt, overlap_cnt);
            failures++;
        end
        checks++;
        if (got_q.size() != 3) begin $display("FAIL gaps_count got=%0d exp=3", got_q.size()); failures++; end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                $display("FAIL gaps_result%0d got=%h exp=%h", k, got_q[k], exp_q[k]); failures++;
            end
        end
    endtask

    task automatic test_reset_mid;
        set_weights(0);
        rand_vecs(3);
        res_ready = 0;
        start_job(6);
        send_weights(0);
        send_acts(0);
        cycles(10);
        checks++;
        if (res_valid !== 1'b1) begin $display("FAIL mid_prefill got=%b exp=1", res_valid); failures++; end
        rst = 1;
        cycles(1);
        test_reset();
        cycles(2);
        rst = 0;
        checks++;
        if (done_cnt != 0) begin $display("FAIL mid_abort_done got=%0d exp=0", done_cnt); failures++; end
        set_weights(0);
        rand_vecs(3);
        res_ready = 1;
        start_job(3);
        send_weights(0);
        send_acts(0);
        wait_done(200);
        checks++;
        if (got_q.size() != 3 || done_cnt != 1) begin
            $display("FAIL mid_new_job got results=%0d done=%0d exp results=3 done=1", got_q.size(), done_cnt);
            failures++;
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                $display("FAIL mid_result%0d got=%h exp=%h", k, got_q[k], exp_q[k]); failures++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) hist[k] = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = '0;
        cycles(3);
        test_reset();
        rst = 0;
        cycles(2);
        test_basic();
        test_bubbles();
        test_backpressure();
        test_zero();
        test_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
